// File: rtl/seq_pkg.sv
// Shared mode encodings and helpers for the sequence counter.
// Mode codes match the 2-bit mode input.
package seq_pkg;

    localparam logic [1:0] MODE_BIN  = 2'd0;
    localparam logic [1:0] MODE_GRAY = 2'd1;
    localparam logic [1:0] MODE_JOHN = 2'd2;
    localparam logic [1:0] MODE_RING = 2'd3;

    // Caller zero-extends; a vector is one-hot when exactly one bit is set.
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/seq_gray_enc.sv
// Combinational binary-to-Gray encoder.
module seq_gray_enc #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/seq_counter_gen.sv
// Up/down sequence generator: binary, Gray, Johnson and one-hot ring outputs,
// with programmable modulus, load, enable and a registered terminal-count pulse.
module seq_counter_gen
    import seq_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ud,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] mod_max,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] qf,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] qf_q, qf_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] shift_d;
    logic [WIDTH-1:0] idx_gray;
    logic [WIDTH-1:0] shift_nxt;

    seq_gray_enc #(.WIDTH(WIDTH)) u_gray_enc (
        .bin  (idx_d),
        .gray (idx_gray)
    );

    // idx drives binary/Gray; shift_d holds the Johnson/ring pattern directly.
    always_comb begin
        mode_d    = mode_q;
        idx_d     = idx_q;
        shift_d   = qf_q;
        tc_d      = 1'b0;
        shift_nxt = qf_q;

        if (mode != mode_q) begin
            mode_d  = mode;
            idx_d   = '0;
            shift_d = (mode == MODE_RING) ? ONE : '0;
        end else if (mode_q == MODE_BIN || mode_q == MODE_GRAY) begin
            if (ld) begin
                idx_d = (ld_val > mod_max) ? mod_max : ld_val;
            end else if (en) begin
                if (idx_q > mod_max) begin
                    // Modulus was lowered below the current index: re-enter range silently.
                    idx_d = ud ? '0 : mod_max;
                end else if (ud) begin
                    if (idx_q == mod_max) begin
                        idx_d = '0;
                        tc_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + ONE;
                    end
                end else begin
                    if (idx_q == '0) begin
                        idx_d = mod_max;
                        tc_d  = 1'b1;
                    end else begin
                        idx_d = idx_q - ONE;
                    end
                end
            end
        end else if (mode_q == MODE_JOHN) begin
            if (ld) begin
                shift_d = ld_val;
            end else if (en) begin
                shift_nxt = ud ? {qf_q[WIDTH-2:0], ~qf_q[WIDTH-1]}
                               : {~qf_q[0], qf_q[WIDTH-1:1]};
                shift_d   = shift_nxt;
                tc_d      = (shift_nxt == '0);
            end
        end else begin
            if (ld) begin
                shift_d = ld_val;
            end else if (en) begin
                if (!is_onehot(32'(qf_q))) begin
                    shift_d = ONE;
                end else begin
                    shift_nxt = ud ? {qf_q[WIDTH-2:0], qf_q[WIDTH-1]}
                                   : {qf_q[0], qf_q[WIDTH-1:1]};
                    shift_d   = shift_nxt;
                    tc_d      = (shift_nxt == ONE);
                end
            end
        end
    end

    assign qf_d = (mode_d == MODE_BIN)  ? idx_d    :
                  (mode_d == MODE_GRAY) ? idx_gray : shift_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= MODE_BIN;
            idx_q  <= '0;
            qf_q   <= '0;
            tc_q   <= 1'b0;
        end else begin
            mode_q <= mode_d;
            idx_q  <= idx_d;
            qf_q   <= qf_d;
            tc_q   <= tc_d;
        end
    end

    assign qf = qf_q;
    assign tc = tc_q;

endmodule

// File: tb/tb_seq_counter_gen.sv
// Directed bench for seq_counter_gen at WIDTH=3 with hand-computed expectations.
module tb_seq_counter_gen;

    logic       clk;
    logic       rst;
    logic       en;
    logic       ud;
    logic [1:0] mode;
    logic [2:0] mod_max;
    logic       ld;
    logic [2:0] ld_val;
    logic [2:0] qf;
    logic       tc;

    int n_vec;
    int n_err;

    seq_counter_gen #(.WIDTH(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .ud      (ud),
        .mode    (mode),
        .mod_max (mod_max),
        .ld      (ld),
        .ld_val  (ld_val),
        .qf      (qf),
        .tc      (tc)
    );

    initial clk = 1'b0;
    always #40 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] exp_qf, input logic exp_tc);
        n_vec++;
        assert (qf === exp_qf) else begin
            n_err++;
            $error("FAIL %s qf: observed %b expected %b", tag, qf, exp_qf);
        end
        n_vec++;
        assert (tc === exp_tc) else begin
            n_err++;
            $error("FAIL %s tc: observed %b expected %b", tag, tc, exp_tc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b1;
        en      = 1'b0;
        ud      = 1'b1;
        mode    = 2'd0;
        mod_max = 3'd5;
        ld      = 1'b0;
        ld_val  = 3'd0;
        #100;
        chk("reset", 3'b000, 1'b0);
        rst = 1'b0;

        // binary up, mod_max=5
        en = 1'b1;
        step(); chk("bin_up1", 3'd1, 1'b0);
        step(); chk("bin_up2", 3'd2, 1'b0);
        step(); chk("bin_up3", 3'd3, 1'b0);
        step(); chk("bin_up4", 3'd4, 1'b0);
        step(); chk("bin_up5", 3'd5, 1'b0);
        step(); chk("bin_wrap_up", 3'd0, 1'b1);
        ud = 1'b0;
        step(); chk("bin_wrap_dn", 3'd5, 1'b1);
        step(); chk("bin_dn4", 3'd4, 1'b0);

        // async reset between edges
        #10;
        rst = 1'b1;
        #5;
        chk("async_rst", 3'b000, 1'b0);
        rst = 1'b0;
        ud  = 1'b1;
        step(); chk("resume", 3'd1, 1'b0);

        // Gray full cycle, mod_max=7
        mode = 2'd1; mod_max = 3'd7;
        step(); chk("gray_enter", 3'b000, 1'b0);
        step(); chk("gray1", 3'b001, 1'b0);
        step(); chk("gray2", 3'b011, 1'b0);
        step(); chk("gray3", 3'b010, 1'b0);
        step(); chk("gray4", 3'b110, 1'b0);
        step(); chk("gray5", 3'b111, 1'b0);
        step(); chk("gray6", 3'b101, 1'b0);
        step(); chk("gray7", 3'b100, 1'b0);
        step(); chk("gray_wrap", 3'b000, 1'b1);
        mod_max = 3'd5; ld = 1'b1; ld_val = 3'd7;
        step(); chk("gray_ld_clamp", 3'b111, 1'b0);
        ld = 1'b0;

        // Johnson
        mode = 2'd2;
        step(); chk("john_enter", 3'b000, 1'b0);
        step(); chk("john1", 3'b001, 1'b0);
        step(); chk("john2", 3'b011, 1'b0);
        step(); chk("john3", 3'b111, 1'b0);
        step(); chk("john4", 3'b110, 1'b0);
        step(); chk("john5", 3'b100, 1'b0);
        step(); chk("john_wrap", 3'b000, 1'b1);
        ud = 1'b0;
        step(); chk("john_dn1", 3'b100, 1'b0);
        step(); chk("john_dn2", 3'b110, 1'b0);
        en = 1'b0;
        step(); chk("john_hold", 3'b110, 1'b0);

        // Ring
        en = 1'b1; mode = 2'd3;
        step(); chk("ring_enter", 3'b001, 1'b0);
        ld = 1'b1; ld_val = 3'b110;
        step(); chk("ring_ld", 3'b110, 1'b0);
        ld = 1'b0;
        step(); chk("ring_fix", 3'b001, 1'b0);
        ud = 1'b1;
        step(); chk("ring_up1", 3'b010, 1'b0);
        step(); chk("ring_up2", 3'b100, 1'b0);
        step(); chk("ring_wrap", 3'b001, 1'b1);
        ud = 1'b0;
        step(); chk("ring_dn1", 3'b100, 1'b0);
        step(); chk("ring_dn2", 3'b010, 1'b0);
        step(); chk("ring_dn_wrap", 3'b001, 1'b1);

        // mode change beats load
        ud = 1'b1; mode = 2'd0; mod_max = 3'd5;
        step(); chk("bin_enter", 3'd0, 1'b0);
        step(); step(); step();
        step(); chk("bin_at4", 3'd4, 1'b0);
        mode = 2'd1; ld = 1'b1; ld_val = 3'd6;
        step(); chk("mode_over_ld", 3'b000, 1'b0);
        mod_max = 3'd7;
        step(); chk("gray_ld6", 3'b101, 1'b0);
        ld = 1'b0;

        // modulus lowered below index, then zero modulus
        mod_max = 3'd3;
        step(); chk("above_max_up", 3'b000, 1'b0);
        mod_max = 3'd0;
        step(); chk("mod0_up", 3'b000, 1'b1);
        ud = 1'b0;
        step(); chk("mod0_dn", 3'b000, 1'b1);
        en = 1'b0;
        step(); chk("mod0_hold", 3'b000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
